opacc_drain: RTL and testbench

Read-out controller for the outer-product accumulator: after C += A*B accumulation it unloads the `ml` accumulator rows from `opacc.vo_c` one row per transfer. Rows go out through a valid/ready port toward vector-register writeback. It is the unload counterpart of the C-load sequencing in `shift_fsm`. It sits beside `opacc` and owns its C shift enable only while draining.

---
 rtl/opacc_pkg.sv | 19 +
 rtl/opacc_drain.sv | 125 ++++++++++++
 tb/tb_opacc_drain.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/opacc_pkg.sv
// opacc_pkg: types and defaults shared by the outer-product accumulator slice.
//   XLEN_DEFAULT / VL_DEFAULT / ML_DEFAULT : default element width, elements
//                                            per row, rows in the accumulator
//   row_t         : one accumulator row at the default geometry
//   drain_state_e : read-out controller states
package opacc_pkg;

   localparam int XLEN_DEFAULT = 64;
   localparam int VL_DEFAULT   = 2;
   localparam int ML_DEFAULT   = 2;

   typedef logic [VL_DEFAULT-1:0][XLEN_DEFAULT-1:0] row_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } drain_state_e;

endpackage

// File: rtl/opacc_drain.sv
// opacc_drain: unloads the ml accumulator rows of opacc one row per transfer
// after an accumulation, presenting them on a valid/ready port.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   start     in   drain request, only looked at in IDLE
//   vi_row    in   head row of the accumulator (opacc.vo_c)
//   shift_c   out  advance the accumulator by one row this cycle
//   busy      out  from the cycle after start is accepted through the done cycle
//   done      out  one-cycle pulse after the last row handshake
//   out_valid out  out_data holds a valid row
//   out_ready in   downstream accepts the row
//   out_data  out  registered row
//   out_idx   out  row index of out_data, 0 first
//   out_last  out  out_data is row ml-1
//   state_o   out  current controller state, for observation
//
// Handshake: a row transfers on a rising edge where out_valid and out_ready
// are both high. Once out_valid is raised, out_data/out_idx/out_last hold
// unchanged until that transfer; out_valid never drops without a transfer
// except on reset.
module opacc_drain
   import opacc_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int vl   = VL_DEFAULT,
   parameter int ml   = ML_DEFAULT,
   localparam int IW  = (ml > 1) ? $clog2(ml) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [vl-1:0][XLEN-1:0]   vi_row,
   output logic                      shift_c,
   output logic                      busy,
   output logic                      done,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [vl-1:0][XLEN-1:0]   out_data,
   output logic [IW-1:0]             out_idx,
   output logic                      out_last,
   output drain_state_e              state_o
);

   localparam logic [IW-1:0] LAST_IDX = IW'(ml - 1);

   drain_state_e              state_q,     state_d;
   logic [vl-1:0][XLEN-1:0]   out_data_q,  out_data_d;
   logic [IW-1:0]             out_idx_q,   out_idx_d;
   logic                      out_valid_q, out_valid_d;
   logic                      done_q,      done_d;
   logic                      busy_q,      busy_d;
   logic                      shift_raw;

   // Every shift of the accumulator coincides with a capture of its head row
   // into out_data, so each row is taken exactly once.
   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      shift_raw   = 1'b0;
      case (state_q)
         IDLE: begin
            out_valid_d = 1'b0;
            out_idx_d   = '0;
            if (start) begin
               out_data_d  = vi_row;
               shift_raw   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (out_valid_q && out_ready) begin
               if (out_idx_q == LAST_IDX) begin
                  out_valid_d = 1'b0;
                  out_idx_d   = '0;
                  done_d      = 1'b1;
                  state_d     = IDLE;
               end else begin
                  out_data_d = vi_row;
                  shift_raw  = 1'b1;
                  out_idx_d  = out_idx_q + IW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // busy covers the whole SEND period plus the done cycle.
      busy_d = (state_d == SEND) || done_d;
   end

   // A reset cycle must not advance the accumulator.
   assign shift_c = shift_raw & reset;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_valid_q && (out_idx_q == LAST_IDX);
   assign done      = done_q;
   assign busy      = busy_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_opacc_drain.sv
// tb_opacc_drain: bench for opacc_drain at ml=1, ml=2 and ml=4. Each instance
// reads from a behavioural accumulator that drops its head row and feeds zero
// at the tail on every shift_c pulse, as the top level does while busy.
module tb_opacc_drain;
   import opacc_pkg::*;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- ml = 2 instance ----------------
   logic         start2, out_ready2, shift_c2, busy2, done2, out_valid2, out_last2;
   row_t         vi_row2, out_data2;
   logic [0:0]   out_idx2;
   drain_state_e state2;
   row_t         acc2 [2];
   row_t         load_val2 [2];
   logic         load_en2;
   int           shift_cnt2 = 0;

   opacc_drain #(.XLEN(64), .vl(2), .ml(2)) u_drain2 (
      .clk(clk), .reset(reset), .start(start2), .vi_row(vi_row2),
      .shift_c(shift_c2), .busy(busy2), .done(done2), .out_valid(out_valid2),
      .out_ready(out_ready2), .out_data(out_data2), .out_idx(out_idx2),
      .out_last(out_last2), .state_o(state2)
   );

   assign vi_row2 = acc2[0];
   always @(posedge clk) begin
      if (load_en2) begin
         acc2[0] <= load_val2[0];
         acc2[1] <= load_val2[1];
      end else if (shift_c2) begin
         acc2[0] <= acc2[1];
         acc2[1] <= '0;
      end
      if (shift_c2) shift_cnt2 <= shift_cnt2 + 1;
   end

   // ---------------- ml = 1 instance ----------------
   logic         start1, out_ready1, shift_c1, busy1, done1, out_valid1, out_last1;
   row_t         vi_row1, out_data1;
   logic [0:0]   out_idx1;
   drain_state_e state1;
   row_t         acc1;
   row_t         load_val1;
   logic         load_en1;
   int           shift_cnt1 = 0;

   opacc_drain #(.XLEN(64), .vl(2), .ml(1)) u_drain1 (
      .clk(clk), .reset(reset), .start(start1), .vi_row(vi_row1),
      .shift_c(shift_c1), .busy(busy1), .done(done1), .out_valid(out_valid1),
      .out_ready(out_ready1), .out_data(out_data1), .out_idx(out_idx1),
      .out_last(out_last1), .state_o(state1)
   );

   assign vi_row1 = acc1;
   always @(posedge clk) begin
      if (load_en1) acc1 <= load_val1;
      else if (shift_c1) acc1 <= '0;
      if (shift_c1) shift_cnt1 <= shift_cnt1 + 1;
   end

   // ---------------- ml = 4 instance ----------------
   logic         start4, out_ready4, shift_c4, busy4, done4, out_valid4, out_last4;
   row_t         vi_row4, out_data4;
   logic [1:0]   out_idx4;
   drain_state_e state4;
   row_t         acc4 [4];
   row_t         load_val4 [4];
   logic         load_en4;
   int           shift_cnt4 = 0;

   opacc_drain #(.XLEN(64), .vl(2), .ml(4)) u_drain4 (
      .clk(clk), .reset(reset), .start(start4), .vi_row(vi_row4),
      .shift_c(shift_c4), .busy(busy4), .done(done4), .out_valid(out_valid4),
      .out_ready(out_ready4), .out_data(out_data4), .out_idx(out_idx4),
      .out_last(out_last4), .state_o(state4)
   );

   assign vi_row4 = acc4[0];
   always @(posedge clk) begin
      if (load_en4) begin
         for (int k = 0; k < 4; k++) acc4[k] <= load_val4[k];
      end else if (shift_c4) begin
         for (int k = 0; k < 3; k++) acc4[k] <= acc4[k+1];
         acc4[3] <= '0;
      end
      if (shift_c4) shift_cnt4 <= shift_cnt4 + 1;
   end

   row_t exp_q [$];

   function automatic row_t mk_row(input logic [63:0] e0, input logic [63:0] e1);
      row_t r;
      r[0] = e0;
      r[1] = e1;
      return r;
   endfunction

   task automatic load2(input row_t r0, input row_t r1);
      @(negedge clk);
      load_val2[0] = r0;
      load_val2[1] = r1;
      load_en2     = 1'b1;
      @(negedge clk);
      load_en2     = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid2); end
      checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy2); end
      checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done2); end
      checks++; if (out_idx2 !== 1'b0 || out_last2 !== 1'b0) begin errors++; $display("FAIL reset_idx_last: got idx %0d last %b want 0 0", out_idx2, out_last2); end
      checks++; if (out_data2 !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data2); end
      checks++; if (state2 !== IDLE || shift_c2 !== 1'b0) begin errors++; $display("FAIL reset_state: got state %0d shift %b want IDLE 0", state2, shift_c2); end
      checks++; if (out_valid4 !== 1'b0 || out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_other_inst: got v4 %b v1 %b want 0 0", out_valid4, out_valid1); end
      reset = 1'b1;
   endtask

   task automatic test_drain_ready();
      row_t r0, r1;
      int   base;
      r0 = mk_row(64'd1, 64'd1);
      r1 = mk_row(64'd1, 64'd2);
      load2(r0, r1);
      base = shift_cnt2;
      @(negedge clk);
      start2 = 1'b1; out_ready2 = 1'b1;
      #1;
      checks++; if (shift_c2 !== 1'b1) begin errors++; $display("FAIL dr_start_shift: got %b want 1", shift_c2); end
      checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL dr_busy_at_start: got %b want 0", busy2); end
      @(negedge clk);
      start2 = 1'b0;
      checks++; if (out_valid2 !== 1'b1 || busy2 !== 1'b1) begin errors++; $display("FAIL dr_first_valid: got v %b busy %b want 1 1", out_valid2, busy2); end
      checks++; if (out_data2 !== r0 || out_idx2 !== 1'b0 || out_last2 !== 1'b0) begin errors++; $display("FAIL dr_row0: got %h idx %0d last %b want %h 0 0", out_data2, out_idx2, out_last2, r0); end
      @(negedge clk);
      checks++; if (out_valid2 !== 1'b1 || out_data2 !== r1 || out_idx2 !== 1'b1 || out_last2 !== 1'b1) begin errors++; $display("FAIL dr_row1: got v %b %h idx %0d last %b want 1 %h 1 1", out_valid2, out_data2, out_idx2, out_last2, r1); end
      @(negedge clk);
      checks++; if (done2 !== 1'b1 || busy2 !== 1'b1 || out_valid2 !== 1'b0 || out_last2 !== 1'b0) begin errors++; $display("FAIL dr_done: got done %b busy %b v %b last %b want 1 1 0 0", done2, busy2, out_valid2, out_last2); end
      out_ready2 = 1'b0;
      @(negedge clk);
      checks++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL dr_after_done: got done %b busy %b want 0 0", done2, busy2); end
      checks++; if (acc2[0] !== '0 || acc2[1] !== '0) begin errors++; $display("FAIL dr_acc_zero: got %h %h want 0 0", acc2[0], acc2[1]); end
      checks++; if (shift_cnt2 - base != 2) begin errors++; $display("FAIL dr_shift_count: got %0d want 2", shift_cnt2 - base); end
   endtask

   task automatic test_backpressure();
      row_t  exp_rows [2];
      bit    pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      int    got, base;
      exp_rows[0] = mk_row(64'd1, 64'd1);
      exp_rows[1] = mk_row(64'd1, 64'd2);
      load2(exp_rows[0], exp_rows[1]);
      base = shift_cnt2;
      got  = 0;
      @(negedge clk);
      start2 = 1'b1;
      for (int p = 0; p < 5; p++) begin
         @(negedge clk);
         start2     = 1'b0;
         out_ready2 = pat[p];
         #1;
         checks++; if (out_valid2 !== 1'b1 || out_data2 !== exp_rows[got] || out_idx2 !== 1'(got)) begin errors++; $display("FAIL bp_row_c%0d: got v %b %h idx %0d want 1 %h %0d", p, out_valid2, out_data2, out_idx2, exp_rows[got], got); end
         checks++; if (shift_c2 !== (pat[p] && got < 1)) begin errors++; $display("FAIL bp_shift_c%0d: got %b want %b", p, shift_c2, (pat[p] && got < 1)); end
         if (pat[p]) got++;
      end
      @(negedge clk);
      out_ready2 = 1'b0;
      checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done2); end
      checks++; if (shift_cnt2 - base != 2) begin errors++; $display("FAIL bp_shift_count: got %0d want 2", shift_cnt2 - base); end
   endtask

   task automatic test_start_ignored();
      row_t a, b;
      int   got, dones, base, cyc;
      a = mk_row(64'($urandom), 64'($urandom));
      b = mk_row(64'($urandom), 64'($urandom));
      load2(a, b);
      base = shift_cnt2; got = 0; dones = 0; cyc = 0;
      @(negedge clk);
      start2 = 1'b1; out_ready2 = 1'b1;
      while (dones == 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (done2 === 1'b1) begin
            dones++;
            start2 = 1'b0;
         end else if (out_valid2 === 1'b1) begin
            checks++; if (out_data2 !== ((got == 0) ? a : b)) begin errors++; $display("FAIL si_row%0d: got %h want %h", got, out_data2, (got == 0) ? a : b); end
            got++;
         end
      end
      checks++; if (dones != 1 || got != 2) begin errors++; $display("FAIL si_single_drain: got dones %0d rows %0d want 1 2", dones, got); end
      repeat (4) @(negedge clk);
      out_ready2 = 1'b0;
      checks++; if (busy2 !== 1'b0 || out_valid2 !== 1'b0 || shift_cnt2 - base != 2) begin errors++; $display("FAIL si_no_requeue: got busy %b v %b shifts %0d want 0 0 2", busy2, out_valid2, shift_cnt2 - base); end
   endtask

   task automatic test_back_to_back();
      row_t exp_rows [4];
      int   got, dones, base, cyc;
      exp_rows[0] = mk_row(64'($urandom), 64'($urandom));
      exp_rows[1] = mk_row(64'($urandom), 64'($urandom));
      exp_rows[2] = '0;
      exp_rows[3] = '0;
      load2(exp_rows[0], exp_rows[1]);
      base = shift_cnt2; got = 0; dones = 0; cyc = 0;
      @(negedge clk);
      start2 = 1'b1; out_ready2 = 1'b1;
      while (dones < 2 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         start2 = 1'b0;
         if (done2 === 1'b1) begin
            dones++;
            if (dones == 1) start2 = 1'b1;
         end else if (out_valid2 === 1'b1) begin
            if (got < 4) begin
               checks++; if (out_data2 !== exp_rows[got]) begin errors++; $display("FAIL b2b_row%0d: got %h want %h", got, out_data2, exp_rows[got]); end
            end
            got++;
         end
      end
      start2 = 1'b0; out_ready2 = 1'b0;
      checks++; if (dones != 2 || got != 4) begin errors++; $display("FAIL b2b_counts: got dones %0d rows %0d want 2 4", dones, got); end
      checks++; if (shift_cnt2 - base != 4) begin errors++; $display("FAIL b2b_shift_count: got %0d want 4", shift_cnt2 - base); end
   endtask

   task automatic test_reset_mid_drain();
      int dones;
      load2(mk_row(64'd5, 64'd6), mk_row(64'd7, 64'd8));
      @(negedge clk);
      start2 = 1'b1; out_ready2 = 1'b0;
      @(negedge clk);
      start2 = 1'b0;
      checks++; if (out_valid2 !== 1'b1 || out_idx2 !== 1'b0) begin errors++; $display("FAIL rm_stalled: got v %b idx %0d want 1 0", out_valid2, out_idx2); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (out_valid2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0 || out_data2 !== '0 || out_idx2 !== 1'b0 || out_last2 !== 1'b0 || state2 !== IDLE) begin errors++; $display("FAIL rm_outputs: got v %b busy %b done %b data %h idx %0d state %0d want all 0 IDLE", out_valid2, busy2, done2, out_data2, out_idx2, state2); end
      reset = 1'b1;
      dones = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (done2 === 1'b1 || out_valid2 === 1'b1) dones++;
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL rm_no_done: got %0d active cycles want 0", dones); end
   endtask

   task automatic test_ml1();
      row_t r;
      int   base;
      r = mk_row(64'd7, 64'd9);
      @(negedge clk);
      load_val1 = r; load_en1 = 1'b1;
      @(negedge clk);
      load_en1 = 1'b0;
      base = shift_cnt1;
      start1 = 1'b1; out_ready1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checks++; if (out_valid1 !== 1'b1 || out_data1 !== r || out_idx1 !== 1'b0 || out_last1 !== 1'b1) begin errors++; $display("FAIL ml1_row: got v %b %h idx %0d last %b want 1 %h 0 1", out_valid1, out_data1, out_idx1, out_last1, r); end
      @(negedge clk);
      checks++; if (done1 !== 1'b1 || out_valid1 !== 1'b0) begin errors++; $display("FAIL ml1_done: got done %b v %b want 1 0", done1, out_valid1); end
      out_ready1 = 1'b0;
      @(negedge clk);
      checks++; if (acc1 !== '0 || shift_cnt1 - base != 1 || busy1 !== 1'b0) begin errors++; $display("FAIL ml1_after: got acc %h shifts %0d busy %b want 0 1 0", acc1, shift_cnt1 - base, busy1); end
   endtask

   task automatic test_random_ml4();
      int sent, cyc, base;
      bit finished, rdy, acc_zero;
      row_t exp_row;
      for (int d = 0; d < 50; d++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            load_val4[k] = mk_row({$urandom, $urandom}, {$urandom, $urandom});
            exp_q.push_back(load_val4[k]);
         end
         load_en4 = 1'b1;
         @(negedge clk);
         load_en4 = 1'b0;
         base = shift_cnt4;
         start4 = 1'b1; out_ready4 = 1'($urandom_range(0, 1));
         #1;
         checks++; if (shift_c4 !== 1'b1 || busy4 !== 1'b0) begin errors++; $display("FAIL rnd_start_d%0d: got shift %b busy %b want 1 0", d, shift_c4, busy4); end
         sent = 0; finished = 1'b0; cyc = 0;
         while (!finished && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start4 = 1'($urandom_range(0, 1));
            if (done4 === 1'b1) begin
               start4 = 1'b0;
               finished = 1'b1;
               checks++; if (sent != 4 || busy4 !== 1'b1 || out_valid4 !== 1'b0) begin errors++; $display("FAIL rnd_done_d%0d: got rows %0d busy %b v %b want 4 1 0", d, sent, busy4, out_valid4); end
            end else begin
               checks++; if (busy4 !== 1'b1 || out_valid4 !== 1'b1) begin errors++; $display("FAIL rnd_busy_valid_d%0d: got busy %b v %b want 1 1", d, busy4, out_valid4); end
               rdy = 1'($urandom_range(0, 1));
               out_ready4 = rdy;
               #1;
               checks++; if (shift_c4 !== (rdy && sent < 3)) begin errors++; $display("FAIL rnd_shift_d%0d: got %b want %b", d, shift_c4, (rdy && sent < 3)); end
               checks++; if (out_idx4 !== 2'(sent) || out_last4 !== (sent == 3)) begin errors++; $display("FAIL rnd_idx_d%0d: got idx %0d last %b want %0d %b", d, out_idx4, out_last4, sent, (sent == 3)); end
               if (exp_q.size() > 0) begin
                  exp_row = exp_q[0];
                  checks++; if (out_data4 !== exp_row) begin errors++; $display("FAIL rnd_data_d%0d_r%0d: got %h want %h", d, sent, out_data4, exp_row); end
               end
               if (rdy) begin
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
                  sent++;
               end
            end
         end
         if (!finished) begin
            errors++; checks++;
            $display("FAIL rnd_timeout_d%0d: got no done within 100 cycles want done", d);
            exp_q.delete();
         end
         @(negedge clk);
         start4 = 1'b0; out_ready4 = 1'b0;
         acc_zero = 1'b1;
         for (int k = 0; k < 4; k++) if (acc4[k] !== '0) acc_zero = 1'b0;
         checks++; if (busy4 !== 1'b0 || done4 !== 1'b0 || shift_cnt4 - base != 4 || !acc_zero) begin errors++; $display("FAIL rnd_end_d%0d: got busy %b done %b shifts %0d acc_zero %b want 0 0 4 1", d, busy4, done4, shift_cnt4 - base, acc_zero); end
      end
   endtask

   initial begin
      reset = 1'b0;
      start1 = 1'b0; out_ready1 = 1'b0; load_en1 = 1'b0; load_val1 = '0;
      start2 = 1'b0; out_ready2 = 1'b0; load_en2 = 1'b0;
      start4 = 1'b0; out_ready4 = 1'b0; load_en4 = 1'b0;
      for (int k = 0; k < 2; k++) load_val2[k] = '0;
      for (int k = 0; k < 4; k++) load_val4[k] = '0;
      test_reset();
      test_drain_ready();
      test_backpressure();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_drain();
      test_ml1();
      test_random_ml4();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of run within 500000 time units want completion");
      $fatal(1);
   end

endmodule
